// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth partial-product accumulator:
// default operand width, group count, FSM encoding and a single-group decode helper.
package booth_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_GROUPS = DEFAULT_WIDTH / 2;
  localparam int DEFAULT_PW     = 2 * DEFAULT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Zero wins over double/invert so encoder groups 000/111 decode to 0.
  function automatic logic signed [DEFAULT_PW-1:0] booth_pp(
    input logic signed [DEFAULT_PW-1:0] xs,
    input logic                         dbl,
    input logic                         inv,
    input logic                         zro
  );
    logic signed [DEFAULT_PW-1:0] mag;
    logic signed [DEFAULT_PW-1:0] one;
    one = 1;
    mag = dbl ? (xs <<< 1) : xs;
    if (zro)
      return '0;
    else if (inv)
      return ~mag + one;
    else
      return mag;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational decode of one Booth group into a signed partial product
// (0, +/-X, +/-2X) at full product width.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic signed [2*WIDTH-1:0] xs,
  input  logic                      dbl,
  input  logic                      inv,
  input  logic                      zro,
  output logic signed [2*WIDTH-1:0] pp
);

  localparam logic signed [2*WIDTH-1:0] ONE = 1;

  logic signed [2*WIDTH-1:0] mag;

  always_comb begin
    mag = dbl ? (xs <<< 1) : xs;
    if (zro)
      pp = '0;
    else if (inv)
      pp = ~mag + ONE;
    else
      pp = mag;
  end

endmodule

// File: rtl/booth_pp_accumulator.sv
// Radix-4 Booth consumer: decodes one group per cycle, shifts it into place
// and accumulates the signed product; valid/ready handshake on both sides.
module booth_pp_accumulator
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   X,
  input  logic [WIDTH/2-1:0]        double_X,
  input  logic [WIDTH/2-1:0]        invert_X,
  input  logic [WIDTH/2-1:0]        zero_X,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [2*WIDTH-1:0] product
);

  localparam int GROUPS = WIDTH / 2;
  localparam int PW     = 2 * WIDTH;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

  state_t                  state_p0, state_nx;
  logic [CNT_W-1:0]        cnt_p0;
  logic signed [WIDTH-1:0] x_p0;
  logic [GROUPS-1:0]       dbl_p0, inv_p0, zro_p0;
  logic signed [PW-1:0]    acc_p1;

  logic signed [PW-1:0]    xs;
  logic signed [PW-1:0]    pp;
  logic signed [PW-1:0]    pp_sh;

  assign xs    = $signed({{WIDTH{x_p0[WIDTH-1]}}, x_p0});
  assign pp_sh = pp <<< {cnt_p0, 1'b0};

  booth_pp_gen #(
    .WIDTH (WIDTH)
  ) u_pp_gen (
    .xs  (xs),
    .dbl (dbl_p0[cnt_p0]),
    .inv (inv_p0[cnt_p0]),
    .zro (zro_p0[cnt_p0]),
    .pp  (pp)
  );

  always_comb begin
    state_nx  = state_p0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_p0)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ACC;
      end
      ACC: begin
        if (cnt_p0 == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Stage p0 captures operands on accept; stage p1 is the running accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      acc_p1   <= '0;
    end else begin
      state_p0 <= state_nx;
      case (state_p0)
        IDLE: begin
          if (in_valid) begin
            x_p0   <= X;
            dbl_p0 <= double_X;
            inv_p0 <= invert_X;
            zro_p0 <= zero_X;
            acc_p1 <= '0;
            cnt_p0 <= '0;
          end
        end
        ACC: begin
          acc_p1 <= acc_p1 + pp_sh;
          cnt_p0 <= cnt_p0 + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product = acc_p1;

endmodule
